// File: rtl/pa_fcnvt_ftoi_pipe_if.sv
// Request/response bundle for the float-to-integer convert pipe.
// The master side issues conversions and consumes results; the slave side is the converter.
interface pa_fcnvt_ftoi_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
);
   localparam int FLEN = 1 + EXP_W + MAN_W;

   logic             ftoi_in_vld;
   logic             ftoi_in_rdy;
   logic [FLEN-1:0]  ftoi_in_src;
   logic [2:0]       ftoi_in_rm;
   logic             ftoi_in_unsigned;
   logic [TAG_W-1:0] ftoi_in_tag;
   logic             ftoi_out_vld;
   logic             ftoi_out_rdy;
   logic [XLEN-1:0]  ftoi_out_result;
   logic             ftoi_out_nv;
   logic             ftoi_out_nx;
   logic [TAG_W-1:0] ftoi_out_tag;

   modport master (
      output ftoi_in_vld, ftoi_in_src, ftoi_in_rm, ftoi_in_unsigned, ftoi_in_tag, ftoi_out_rdy,
      input  ftoi_in_rdy, ftoi_out_vld, ftoi_out_result, ftoi_out_nv, ftoi_out_nx, ftoi_out_tag
   );

   modport slave (
      input  ftoi_in_vld, ftoi_in_src, ftoi_in_rm, ftoi_in_unsigned, ftoi_in_tag, ftoi_out_rdy,
      output ftoi_in_rdy, ftoi_out_vld, ftoi_out_result, ftoi_out_nv, ftoi_out_nx, ftoi_out_tag
   );
endinterface

// File: rtl/pa_fcnvt_ftoi_pipe.sv
// Two-stage float-to-integer converter: stage 1 aligns and extracts guard/sticky, stage 2 rounds and saturates.
// Optional macro PA_FCNVT_FTOI_FLUSH_EN adds the ftoi_flush input that kills both stages.
module pa_fcnvt_ftoi_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input logic forever_cpuclk,
   input logic cpurst_b,
`ifdef PA_FCNVT_FTOI_FLUSH_EN
   input logic ftoi_flush,
`endif
   pa_fcnvt_ftoi_pipe_if.slave ftoi
);
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;
   localparam int FX_W = XLEN + MAN_W + 1;
   localparam int SH_W = $clog2(XLEN + 1);
   localparam int E_W  = EXP_W + 2;
   localparam logic [XLEN:0]   NEG_LIM = (XLEN + 1)'(1) << (XLEN - 1);
   localparam logic [XLEN:0]   POS_LIM = NEG_LIM - (XLEN + 1)'(1);
   localparam logic [XLEN-1:0] SMAX    = {1'b0, {(XLEN - 1){1'b1}}};
   localparam logic [XLEN-1:0] SMIN    = {1'b1, {(XLEN - 1){1'b0}}};

   typedef enum logic [2:0] {
      RM_RNE = 3'd0,
      RM_RTZ = 3'd1,
      RM_RDN = 3'd2,
      RM_RUP = 3'd3,
      RM_RMM = 3'd4
   } rm_e;

   logic s1_vld, s2_vld, s2_free, in_rdy, in_fire;

   logic                    sign_in;
   logic [EXP_W-1:0]        exp_in;
   logic [MAN_W-1:0]        frac_in;
   logic [MAN_W:0]          sig_in;
   logic signed [E_W-1:0]   e_unb, e_p1;
   logic                    is_nan_in, is_ovf_in;
   logic [FX_W-1:0]         fx;
   logic [XLEN-1:0]         int_d;
   logic                    g_d, s_d;

   logic                    s1_sign, s1_nan, s1_ovf, s1_g, s1_s, s1_uns;
   logic [XLEN-1:0]         s1_int;
   logic [2:0]              s1_rm;
   logic [TAG_W-1:0]        s1_tag;

   logic                    inc;
   logic [XLEN:0]           mag;
   logic [XLEN-1:0]         res_d;
   logic                    nv_d, nx_d;

   logic [XLEN-1:0]         s2_result;
   logic                    s2_nv, s2_nx;
   logic [TAG_W-1:0]        s2_tag;

   assign s2_free = ~s2_vld | ftoi.ftoi_out_rdy;
`ifdef PA_FCNVT_FTOI_FLUSH_EN
   assign in_rdy  = (~s1_vld | s2_free) & ~ftoi_flush;
`else
   assign in_rdy  = ~s1_vld | s2_free;
`endif
   assign in_fire = ftoi.ftoi_in_vld & in_rdy;

   assign {sign_in, exp_in, frac_in} = ftoi.ftoi_in_src;
   assign sig_in    = {|exp_in, frac_in};
   assign e_unb     = signed'({2'b00, exp_in}) - signed'(E_W'(BIAS));
   assign e_p1      = e_unb + signed'(E_W'(1));
   assign is_nan_in = (&exp_in) & (|frac_in);
   assign is_ovf_in = (&exp_in) | (e_unb >= signed'(E_W'(XLEN)));

   // fx holds the value as a fixed-point number with MAN_W+1 fraction bits, so
   // the integer part, guard bit and sticky field fall at fixed positions.
   always_comb begin
      fx    = '0;
      int_d = '0;
      g_d   = 1'b0;
      s_d   = 1'b0;
      if (!is_ovf_in) begin
         if (e_p1 < signed'(E_W'(0))) begin
            s_d = |sig_in;
         end else begin
            fx    = FX_W'(sig_in) << e_p1[SH_W-1:0];
            int_d = fx[FX_W-1 -: XLEN];
            g_d   = fx[MAN_W];
            s_d   = |fx[MAN_W-1:0];
         end
      end
   end

   always_comb begin
      inc = 1'b0;
      case (s1_rm)
         RM_RNE:  inc = s1_g & (s1_s | s1_int[0]);
         RM_RDN:  inc = s1_sign & (s1_g | s1_s);
         RM_RUP:  inc = ~s1_sign & (s1_g | s1_s);
         RM_RMM:  inc = s1_g;
         default: inc = 1'b0;
      endcase
   end

   assign mag = {1'b0, s1_int} + {{XLEN{1'b0}}, inc};

   // Saturation: an out-of-range value clamps toward its sign; only in-range results may be inexact.
   always_comb begin
      res_d = '0;
      nv_d  = 1'b0;
      nx_d  = 1'b0;
      if (s1_nan) begin
         nv_d  = 1'b1;
         res_d = s1_uns ? '1 : SMAX;
      end else if (s1_uns) begin
         if (s1_sign) begin
            if (s1_ovf || (mag != '0)) nv_d = 1'b1;
            else                       nx_d = s1_g | s1_s;
         end else if (s1_ovf || mag[XLEN]) begin
            nv_d  = 1'b1;
            res_d = '1;
         end else begin
            res_d = mag[XLEN-1:0];
            nx_d  = s1_g | s1_s;
         end
      end else if (s1_sign) begin
         if (s1_ovf || (mag > NEG_LIM)) begin
            nv_d  = 1'b1;
            res_d = SMIN;
         end else begin
            res_d = -mag[XLEN-1:0];
            nx_d  = s1_g | s1_s;
         end
      end else if (s1_ovf || (mag > POS_LIM)) begin
         nv_d  = 1'b1;
         res_d = SMAX;
      end else begin
         res_d = mag[XLEN-1:0];
         nx_d  = s1_g | s1_s;
      end
   end

   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         s1_vld <= 1'b0;
         s2_vld <= 1'b0;
      end
`ifdef PA_FCNVT_FTOI_FLUSH_EN
      else if (ftoi_flush) begin
         s1_vld <= 1'b0;
         s2_vld <= 1'b0;
      end
`endif
      else begin
         if (in_fire)      s1_vld <= 1'b1;
         else if (s2_free) s1_vld <= 1'b0;
         if (s2_free)      s2_vld <= s1_vld;
      end
   end

   always_ff @(posedge forever_cpuclk) begin
      if (in_fire) begin
         s1_sign <= sign_in;
         s1_nan  <= is_nan_in;
         s1_ovf  <= is_ovf_in;
         s1_int  <= int_d;
         s1_g    <= g_d;
         s1_s    <= s_d;
         s1_rm   <= ftoi.ftoi_in_rm;
         s1_uns  <= ftoi.ftoi_in_unsigned;
         s1_tag  <= ftoi.ftoi_in_tag;
      end
   end

   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         s2_result <= '0;
         s2_nv     <= 1'b0;
         s2_nx     <= 1'b0;
         s2_tag    <= '0;
      end else if (s2_free && s1_vld) begin
         s2_result <= res_d;
         s2_nv     <= nv_d;
         s2_nx     <= nx_d;
         s2_tag    <= s1_tag;
      end
   end

   assign ftoi.ftoi_in_rdy     = in_rdy;
   assign ftoi.ftoi_out_vld    = s2_vld;
   assign ftoi.ftoi_out_result = s2_result;
   assign ftoi.ftoi_out_nv     = s2_nv;
   assign ftoi.ftoi_out_nx     = s2_nx;
   assign ftoi.ftoi_out_tag    = s2_tag;
endmodule
